// File: rtl/alu_seq_pkg.sv
// Shared types and ALU encodings for the ALU operation sequencer.
// States, select codes and mode values used by the sequencer and its users.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] ALU_SEL_ADD     = 4'b1001;
  localparam logic [3:0] ALU_SEL_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SEL_AMINUS1 = 4'b1111;
  localparam logic [3:0] ALU_SEL_AND     = 4'b1011;
  localparam logic [3:0] ALU_SEL_OR      = 4'b1110;
  localparam logic [3:0] ALU_SEL_XOR     = 4'b0110;

  localparam logic ALU_MODE_ARITH = 1'b0;
  localparam logic ALU_MODE_LOGIC = 1'b1;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issue stage for a WIDTH-bit ALU; wide ops run as two chained passes.
// Optional ALU_SEQ_ZERO_FLAG_EN adds a registered res_zero output.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wide,
  input  logic               cmd_mode,
  input  logic [3:0]         cmd_select,
  input  logic               cmd_carry_in,
  input  logic [2*WIDTH-1:0] cmd_a,
  input  logic [2*WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0]   alu_in_a,
  output logic [WIDTH-1:0]   alu_in_b,
  output logic [3:0]         alu_select,
  output logic               alu_mode,
  output logic               alu_carry_in,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carry_out,
  input  logic               alu_compare,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_carry,
  output logic               res_equal
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic               res_zero
`endif
);

  state_e state_q, state_d;

  logic               wide_q;
  logic               mode_q;
  logic [3:0]         sel_q;
  logic               cin_q;
  logic [2*WIDTH-1:0] a_q;
  logic [2*WIDTH-1:0] b_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic               carry_q;
  logic               equal_q;

  logic accept;
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = LO;
      LO:      state_d = wide_q ? HI : DONE;
      HI:      state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == IDLE) && !rst;
    alu_select   = sel_q;
    alu_mode     = mode_q;
    alu_in_a     = '0;
    alu_in_b     = '0;
    alu_carry_in = 1'b0;
    case (state_q)
      LO: begin
        alu_in_a     = a_q[WIDTH-1:0];
        alu_in_b     = b_q[WIDTH-1:0];
        alu_carry_in = cin_q;
      end
      HI: begin
        alu_in_a     = a_q[2*WIDTH-1:WIDTH];
        alu_in_b     = b_q[2*WIDTH-1:WIDTH];
        alu_carry_in = carry_q;
      end
      default: ;
    endcase
  end

  // Result registers are cleared on accept so a narrow op leaves the upper half zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wide_q  <= 1'b0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wide_q  <= cmd_wide;
            mode_q  <= cmd_mode;
            sel_q   <= cmd_select;
            cin_q   <= cmd_carry_in;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            equal_q <= 1'b0;
          end
        end
        LO: begin
          lo_q    <= alu_out;
          carry_q <= alu_carry_out;
          equal_q <= alu_compare;
        end
        HI: begin
          hi_q    <= alu_out;
          carry_q <= alu_carry_out;
          equal_q <= equal_q & alu_compare;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (accept) zero_q <= 1'b0;
        LO:      zero_q <= (alu_out == '0);
        HI:      zero_q <= zero_q & (alu_out == '0);
        default: ;
      endcase
    end
  end

  assign res_zero = zero_q;
`endif

  assign res_valid = (state_q == DONE);
  assign res_data  = {hi_q, lo_q};
  assign res_carry = carry_q;
  assign res_equal = equal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural adder ALU stub.
// Zero-flag checks are compiled in when ALU_SEQ_ZERO_FLAG_EN is defined.
module tb_alu_op_sequencer;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_wide;
  logic           cmd_mode;
  logic [3:0]     cmd_select;
  logic           cmd_carry_in;
  logic [2*W-1:0] cmd_a;
  logic [2*W-1:0] cmd_b;
  logic [W-1:0]   alu_in_a;
  logic [W-1:0]   alu_in_b;
  logic [3:0]     alu_select;
  logic           alu_mode;
  logic           alu_carry_in;
  logic [W-1:0]   alu_out;
  logic           alu_carry_out;
  logic           alu_compare;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_data;
  logic           res_carry;
  logic           res_equal;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic           res_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wide     (cmd_wide),
    .cmd_mode     (cmd_mode),
    .cmd_select   (cmd_select),
    .cmd_carry_in (cmd_carry_in),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_select   (alu_select),
    .alu_mode     (alu_mode),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out),
    .alu_carry_out(alu_carry_out),
    .alu_compare  (alu_compare),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_equal    (res_equal)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .res_zero     (res_zero)
`endif
  );

  logic [W:0] sum;
  always_comb begin
    sum = '0;
    if (alu_select == 4'b1001)
      sum = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{W{1'b0}}, alu_carry_in};
    else
      sum = {1'b0, alu_in_a ^ alu_in_b};
    alu_out       = sum[W-1:0];
    alu_carry_out = sum[W];
    alu_compare   = (alu_in_a == alu_in_b);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wide, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
    cmd_valid    = 1'b1;
    cmd_wide     = wide;
    cmd_mode     = 1'b0;
    cmd_select   = 4'b1001;
    cmd_carry_in = cin;
    cmd_a        = a;
    cmd_b        = b;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 10) begin
      step();
      n++;
    end
    check(tag, {31'b0, res_valid}, 32'd1);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    step();
    step();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_eq_cy", {30'b0, res_equal, res_carry}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("idle_alu_a", {16'b0, alu_in_a}, 32'h0);

    // narrow add 3 + 4
    offer(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
    step();
    cmd_valid = 1'b0;
    check("n_lo_ready", {31'b0, cmd_ready}, 32'd0);
    check("n_lo_valid", {31'b0, res_valid}, 32'd0);
    check("n_lo_alu_a", {16'b0, alu_in_a}, 32'h3);
    check("n_lo_alu_b", {16'b0, alu_in_b}, 32'h4);
    check("n_lo_sel", {28'b0, alu_select}, 32'h9);
    step();
    check("n_valid", {31'b0, res_valid}, 32'd1);
    check("n_data", res_data, 32'h0000_0007);
    check("n_eq_cy", {30'b0, res_equal, res_carry}, 32'd0);
    check("n_done_alu_a", {16'b0, alu_in_a}, 32'h0);
    drain();
    check("n_back_idle", {30'b0, cmd_ready, res_valid}, 32'd2);

    // wide add with carry chain
    offer(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    step();
    cmd_valid = 1'b0;
    check("w_lo_alu_a", {16'b0, alu_in_a}, 32'hFFFF);
    check("w_lo_cin", {31'b0, alu_carry_in}, 32'd0);
    step();
    check("w_hi_valid", {31'b0, res_valid}, 32'd0);
    check("w_hi_cin", {31'b0, alu_carry_in}, 32'd1);
    check("w_hi_alu_a", {16'b0, alu_in_a}, 32'h0);
    step();
    check("w_valid", {31'b0, res_valid}, 32'd1);
    check("w_data", res_data, 32'h0001_0000);
    check("w_eq_cy", {30'b0, res_equal, res_carry}, 32'd0);
    drain();

    // wide equal and wide unequal in high half only
    offer(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
    step();
    cmd_valid = 1'b0;
    wait_valid("eq_wait");
    check("eq_equal", {31'b0, res_equal}, 32'd1);
    check("eq_data", res_data, 32'h2468_ACF0);
    drain();
    offer(1'b1, 32'h1234_5678, 32'h1235_5678, 1'b0);
    step();
    cmd_valid = 1'b0;
    wait_valid("ne_wait");
    check("ne_equal", {31'b0, res_equal}, 32'd0);
    check("ne_data", res_data, 32'h2469_ACF0);
    drain();

    // backpressure with a pending command that keeps changing
    offer(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1);
    step();
    offer(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      cmd_a = 32'h0000_0100 + i;
      step();
      check("bp_valid", {31'b0, res_valid}, 32'd1);
      check("bp_data", res_data, 32'h0000_0031);
      check("bp_ready", {31'b0, cmd_ready}, 32'd0);
    end
    cmd_a = 32'h0000_0001;
    drain();
    check("bp_idle_ready", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("bp_next_lo_a", {16'b0, alu_in_a}, 32'h1);
    step();
    check("bp_next_data", res_data, 32'h0000_0002);
    check("bp_next_eq", {31'b0, res_equal}, 32'd1);
    drain();

    // reset while in HI
    offer(1'b1, 32'h0001_0003, 32'h0002_0004, 1'b1);
    step();
    cmd_valid = 1'b0;
    step();
    check("r_in_hi_cin", {31'b0, alu_carry_in}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("r_valid", {31'b0, res_valid}, 32'd0);
    check("r_data", res_data, 32'h0);
    check("r_eq_cy", {30'b0, res_equal, res_carry}, 32'd0);
    check("r_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    step();
    step();
    check("r_still_idle", {30'b0, cmd_ready, res_valid}, 32'd2);

    // narrow wrap to zero; upper operand halves must not leak
    offer(1'b0, 32'hABCD_0005, 32'h1234_FFFB, 1'b0);
    step();
    cmd_valid = 1'b0;
    wait_valid("z_wait");
    check("z_data", res_data, 32'h0);
    check("z_carry", {31'b0, res_carry}, 32'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("z_flag", {31'b0, res_zero}, 32'd1);
`endif
    drain();

`ifdef ALU_SEQ_ZERO_FLAG_EN
    offer(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    step();
    cmd_valid = 1'b0;
    wait_valid("nz_wait");
    check("nz_flag", {31'b0, res_zero}, 32'd0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
